// File: rtl/jtag_target_tap.sv
// jtag_target_tap -- IEEE 1149.1 style test access port with an instruction
// register, a 1-bit bypass register, a boundary-scan register and a
// user-defined data register.
//
// clk acts as TCK; every register samples on its rising edge.
//
// Ports
//   clk, reset          : clock and synchronous active-high reset
//   Trst                : optional TAP reset (present when JTAG_TARGET_TRST_EN
//                         is defined); forces the reset state and a bypass
//                         instruction but leaves the update registers alone
//   Tms, Tdi            : test mode select, serial data in
//   boundaryIn          : parallel pin values captured by the boundary register
//   Tdo, TdoEnable      : serial data out and its valid flag (registered)
//   tapState            : current TAP controller state
//   instruction         : active instruction
//   boundaryOut/userOut : update registers of the boundary and user chains
//   updateDrPulse       : high during the single updateDr cycle
//
// Optional feature macro: JTAG_TARGET_TRST_EN (adds the Trst input).
module jtag_target_tap #(
  parameter int INSTRUCTIONWIDTH = 5,
  parameter int TESTVECTORWIDTH  = 32
) (
  input  logic                        clk,
  input  logic                        reset,
`ifdef JTAG_TARGET_TRST_EN
  input  logic                        Trst,
`endif
  input  logic                        Tms,
  input  logic                        Tdi,
  input  logic [TESTVECTORWIDTH-1:0]  boundaryIn,
  output logic                        Tdo,
  output logic                        TdoEnable,
  output logic [3:0]                  tapState,
  output logic [INSTRUCTIONWIDTH-1:0] instruction,
  output logic [TESTVECTORWIDTH-1:0]  boundaryOut,
  output logic [TESTVECTORWIDTH-1:0]  userOut,
  output logic                        updateDrPulse
);

  localparam int IW = INSTRUCTIONWIDTH;
  localparam int TW = TESTVECTORWIDTH;

  typedef enum logic [3:0] {
    ST_RESET, ST_IDLE, ST_SEL_DR, ST_SEL_IR,
    ST_CAP_IR, ST_SH_IR, ST_EX1_IR, ST_PAU_IR, ST_EX2_IR, ST_UPD_IR,
    ST_CAP_DR, ST_SH_DR, ST_EX1_DR, ST_PAU_DR, ST_EX2_DR, ST_UPD_DR
  } tap_state_e;

  localparam logic [IW-1:0] OP_USER = IW'(1);
  localparam logic [IW-1:0] OP_BSR  = IW'(6);

  tap_state_e    state_q, state_d;
  logic [IW-1:0] ir_sr_q, ir_sr_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          byp_q, byp_d;
  logic [TW-1:0] bsr_sr_q, bsr_sr_d;
  logic [TW-1:0] usr_sr_q, usr_sr_d;
  logic [TW-1:0] bout_q, bout_d;
  logic [TW-1:0] uout_q, uout_d;
  logic          tdo_q, tdo_d;
  logic          ten_q, ten_d;
  logic          upd_q, upd_d;
  logic          trst;
  logic          sel_user, sel_bsr;

`ifdef JTAG_TARGET_TRST_EN
  assign trst = Trst;
`else
  assign trst = 1'b0;
`endif

  // Anything not decoded falls through to bypass.
  assign sel_user = (instr_q == OP_USER);
  assign sel_bsr  = (instr_q == OP_BSR);

  // Controller next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = Tms ? ST_RESET  : ST_IDLE;
      ST_IDLE:   state_d = Tms ? ST_SEL_DR : ST_IDLE;
      ST_SEL_DR: state_d = Tms ? ST_SEL_IR : ST_CAP_DR;
      ST_SEL_IR: state_d = Tms ? ST_RESET  : ST_CAP_IR;
      ST_CAP_IR: state_d = Tms ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  state_d = Tms ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: state_d = Tms ? ST_UPD_IR : ST_PAU_IR;
      ST_PAU_IR: state_d = Tms ? ST_EX2_IR : ST_PAU_IR;
      ST_EX2_IR: state_d = Tms ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: state_d = Tms ? ST_SEL_DR : ST_IDLE;
      ST_CAP_DR: state_d = Tms ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  state_d = Tms ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: state_d = Tms ? ST_UPD_DR : ST_PAU_DR;
      ST_PAU_DR: state_d = Tms ? ST_EX2_DR : ST_PAU_DR;
      ST_EX2_DR: state_d = Tms ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: state_d = Tms ? ST_SEL_DR : ST_IDLE;
      default:   state_d = ST_RESET;
    endcase
    if (trst) state_d = ST_RESET;
  end

  // Data path: capture/shift/update act on the edge leaving the state, so
  // they key off the current state. Pause and the other states hold.
  always_comb begin
    ir_sr_d  = ir_sr_q;
    instr_d  = instr_q;
    byp_d    = byp_q;
    bsr_sr_d = bsr_sr_q;
    usr_sr_d = usr_sr_q;
    bout_d   = bout_q;
    uout_d   = uout_q;
    case (state_q)
      ST_RESET:  instr_d = '0;
      ST_CAP_IR: ir_sr_d = IW'(1);
      ST_SH_IR:  ir_sr_d = {Tdi, ir_sr_q[IW-1:1]};
      ST_UPD_IR: instr_d = ir_sr_q;
      ST_CAP_DR: begin
        if (sel_bsr)       bsr_sr_d = boundaryIn;
        else if (sel_user) usr_sr_d = uout_q;
        else               byp_d    = 1'b0;
      end
      ST_SH_DR: begin
        if (sel_bsr)       bsr_sr_d = {Tdi, bsr_sr_q[TW-1:1]};
        else if (sel_user) usr_sr_d = {Tdi, usr_sr_q[TW-1:1]};
        else               byp_d    = Tdi;
      end
      ST_UPD_DR: begin
        if (sel_bsr)       bout_d = bsr_sr_q;
        else if (sel_user) uout_d = usr_sr_q;
      end
      default: ;
    endcase
    if (trst) instr_d = '0;
  end

  // Outputs are registered from the next-state view so that they line up
  // with tapState while having no combinational path from Tdi/Tms. The
  // instruction cannot change on an edge that enters a shift state, so the
  // current decode is the right one for the next cycle too.
  always_comb begin
    tdo_d = 1'b0;
    ten_d = 1'b0;
    upd_d = (state_d == ST_UPD_DR);
    if (state_d == ST_SH_IR) begin
      tdo_d = ir_sr_d[0];
      ten_d = 1'b1;
    end else if (state_d == ST_SH_DR) begin
      ten_d = 1'b1;
      if (sel_bsr)       tdo_d = bsr_sr_d[0];
      else if (sel_user) tdo_d = usr_sr_d[0];
      else               tdo_d = byp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RESET;
      ir_sr_q  <= '0;
      instr_q  <= '0;
      byp_q    <= 1'b0;
      bsr_sr_q <= '0;
      usr_sr_q <= '0;
      bout_q   <= '0;
      uout_q   <= '0;
      tdo_q    <= 1'b0;
      ten_q    <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_sr_q  <= ir_sr_d;
      instr_q  <= instr_d;
      byp_q    <= byp_d;
      bsr_sr_q <= bsr_sr_d;
      usr_sr_q <= usr_sr_d;
      bout_q   <= bout_d;
      uout_q   <= uout_d;
      tdo_q    <= tdo_d;
      ten_q    <= ten_d;
      upd_q    <= upd_d;
    end
  end

  assign tapState      = state_q;
  assign instruction   = instr_q;
  assign boundaryOut   = bout_q;
  assign userOut       = uout_q;
  assign Tdo           = tdo_q;
  assign TdoEnable     = ten_q;
  assign updateDrPulse = upd_q;

endmodule

// File: tb/tb_jtag_target_tap.sv
// Directed bench for jtag_target_tap (default 5-bit IR, 32-bit chains).
module tb_jtag_target_tap;
  localparam int IW = 5;
  localparam int TW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Tms = 1'b0;
  logic          Tdi = 1'b0;
  logic [TW-1:0] boundaryIn = '0;
  logic          Tdo, TdoEnable, updateDrPulse;
  logic [3:0]    tapState;
  logic [IW-1:0] instruction;
  logic [TW-1:0] boundaryOut, userOut;
`ifdef JTAG_TARGET_TRST_EN
  logic          Trst = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;

  jtag_target_tap #(.INSTRUCTIONWIDTH(IW), .TESTVECTORWIDTH(TW)) dut (
    .clk(clk), .reset(reset),
`ifdef JTAG_TARGET_TRST_EN
    .Trst(Trst),
`endif
    .Tms(Tms), .Tdi(Tdi), .boundaryIn(boundaryIn),
    .Tdo(Tdo), .TdoEnable(TdoEnable), .tapState(tapState),
    .instruction(instruction), .boundaryOut(boundaryOut),
    .userOut(userOut), .updateDrPulse(updateDrPulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One TCK: drive, take the edge, settle 1 time unit after it.
  task automatic tck(input logic tms, input logic tdi);
    Tms = tms;
    Tdi = tdi;
    @(posedge clk);
    #1;
  endtask

  // From idle, shift an instruction in and return to idle.
  task automatic load_ir(input logic [IW-1:0] v);
    tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
    for (int i = 0; i < IW; i++) tck(i == IW - 1, v[i]);
    tck(1, 0);
    tck(0, 0);
    chk("ir_load", 32'(instruction), 32'(v));
  endtask

  // From idle, capture and shift n bits; ends in exit1Dr.
  task automatic scan_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
    dout = '0;
    tck(1, 0); tck(0, 0); tck(0, 0);
    for (int i = 0; i < n; i++) begin
      dout[i] = Tdo;
      tck(i == n - 1, din[i]);
    end
  endtask

  logic [31:0] dout;
  logic [3:0]  obs;
  logic [3:0]  byp_in;

  initial begin
    #1;
    tck(0, 0); tck(1, 0);
    reset = 1'b0;
    chk("rst_state", 32'(tapState), 32'd0);
    chk("rst_instr", 32'(instruction), 32'd0);
    chk("rst_bout", boundaryOut, 32'd0);
    chk("rst_uout", userOut, 32'd0);
    chk("rst_tdo", {30'd0, TdoEnable, Tdo}, 32'd0);
    chk("rst_upd", 32'(updateDrPulse), 32'd0);

    // IR capture pattern visible on Tdo
    tck(0, 0); chk("seq_idle", 32'(tapState), 32'd1);
    tck(1, 0); chk("seq_seldr", 32'(tapState), 32'd2);
    tck(1, 0); chk("seq_selir", 32'(tapState), 32'd3);
    tck(0, 0); chk("seq_capir", 32'(tapState), 32'd4);
    chk("capir_ten", 32'(TdoEnable), 32'd0);
    tck(0, 0); chk("seq_shir", 32'(tapState), 32'd5);
    chk("ir_tdo0", {30'd0, TdoEnable, Tdo}, 32'd3);
    tck(0, 0); chk("ir_tdo1", {30'd0, TdoEnable, Tdo}, 32'd2);
    // five Tms=1 from shiftIr reach reset
    for (int i = 0; i < 5; i++) tck(1, 0);
    chk("tms5_reset", 32'(tapState), 32'd0);
    tck(0, 0);

    // boundary scan: capture 0x0000FFFF, shift in 0xA5A51234
    load_ir(5'b00110);
    boundaryIn = 32'h0000FFFF;
    scan_dr(32'hA5A51234, 32, dout);
    chk("bsr_tdo", dout, 32'h0000FFFF);
    chk("bsr_ex1", 32'(tapState), 32'd12);
    chk("bsr_preupd", boundaryOut, 32'd0);
    chk("bsr_ex1_upd", 32'(updateDrPulse), 32'd0);
    tck(1, 0);
    chk("bsr_upd_st", 32'(tapState), 32'd15);
    chk("bsr_upd_pulse", 32'(updateDrPulse), 32'd1);
    tck(0, 0);
    chk("bsr_upd_pulse_end", 32'(updateDrPulse), 32'd0);
    chk("bsr_bout", boundaryOut, 32'hA5A51234);
    chk("bsr_idle", 32'(tapState), 32'd1);

    // undecoded opcode -> bypass, one cycle delay
    load_ir(5'b00011);
    tck(1, 0); tck(0, 0); tck(0, 0);
    byp_in = 4'b1101; // Tdi 1,0,1,1 in time order (bit0 first)
    for (int i = 0; i < 4; i++) begin
      obs[i] = Tdo;
      tck(0, byp_in[i]);
    end
    chk("byp_tdo", 32'(obs), 32'(4'b1010));
    tck(1, 0); tck(1, 0); tck(0, 0);
    chk("byp_bout_kept", boundaryOut, 32'hA5A51234);

    // user register, park in pauseDr, then escape with five Tms=1
    load_ir(5'b00001);
    tck(1, 0); tck(0, 0); tck(0, 0); // capture userOut (0)
    tck(1, 1);                       // one shift, Tdi=1 enters MSB
    tck(0, 0); chk("pause_st", 32'(tapState), 32'd13);
    tck(0, 0); chk("pause_tdo", {30'd0, TdoEnable, Tdo}, 32'd0);
    tck(1, 0); chk("esc_ex2", 32'(tapState), 32'd14);
    tck(1, 0); chk("esc_upd", 32'(tapState), 32'd15);
    tck(1, 0); chk("esc_seldr", 32'(tapState), 32'd2);
    tck(1, 0); chk("esc_selir", 32'(tapState), 32'd3);
    tck(1, 0); chk("esc_reset", 32'(tapState), 32'd0);
    tck(1, 0);
    chk("esc_instr", 32'(instruction), 32'd0);
    chk("esc_bout", boundaryOut, 32'hA5A51234);
    chk("esc_uout", userOut, 32'h80000000);
    tck(0, 0);

    // load userOut, then reset in the middle of a shift
    load_ir(5'b00001);
    scan_dr(32'h12345678, 32, dout);
    chk("usr_tdo", dout, 32'h80000000);
    tck(1, 0); tck(0, 0);
    chk("usr_uout", userOut, 32'h12345678);
    tck(1, 0); tck(0, 0); tck(0, 0);
    tck(0, 0); tck(0, 0); tck(0, 0);
    chk("usr_mid_tdo", {30'd0, TdoEnable, Tdo}, 32'd3); // bit3 of 0x...78
    reset = 1'b1;
    tck(0, 0);
    reset = 1'b0;
    chk("midrst_state", 32'(tapState), 32'd0);
    chk("midrst_uout", userOut, 32'd0);
    chk("midrst_tdo", {30'd0, TdoEnable, Tdo}, 32'd0);
    chk("midrst_instr", 32'(instruction), 32'd0);
    chk("midrst_bout", boundaryOut, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
